// File: rtl/sat_counter_arbiter.sv
// Round-robin arbiter owning a table of saturating counters: one
// read-modify-write per grant, plus a whole-table clear.
// Optional: define SAT_CNT_STATS_EN to add the sat_hits counter output.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   req/req_inc      per-requester request and op (1=inc, 0=dec)
//   req_idx          per-requester table index, IDX_W bits each
//   clr              pulse: zero every table entry
//   gnt              one-hot grant pulse (high during RMW)
//   busy             high while not IDLE
//   done/done_id     completion pulse and requester served
//   rd_val/pred      counter before update / MSB after update
//   sat_hits         saturating-op count (SAT_CNT_STATS_EN only)
module sat_counter_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 4,
  parameter int CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_inc,
  input  logic [NREQ*IDX_W-1:0]   req_idx,
  input  logic                    clr,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNT_W-1:0]        rd_val,
  output logic                    pred
`ifdef SAT_CNT_STATS_EN
  ,
  output logic [15:0]             sat_hits
`endif
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RMW  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              inc_q, inc_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [CNT_W-1:0]  rd_val_q, rd_val_d;
  logic              pred_q, pred_d;
  logic [CNT_W-1:0]  tbl_q [DEPTH];

  logic [ID_W-1:0]   win;
  logic              any;
  int                j;
  logic [CNT_W-1:0]  old_cnt;
  logic [CNT_W-1:0]  new_cnt;
  logic              sat;

  // first requester at or after the RR pointer, wrapping
  always_comb begin
    win = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_q) + k) % NREQ;
      if (!any && req[j]) begin
        win = ID_W'(j);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    old_cnt = tbl_q[idx_q];
    sat     = inc_q ? (old_cnt == '1)
                    : (old_cnt == '0);
    if (sat)
      new_cnt = old_cnt;
    else if (inc_q)
      new_cnt = old_cnt + 1'b1;
    else
      new_cnt = old_cnt - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    idx_d     = idx_q;
    inc_d     = inc_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    rd_val_d  = rd_val_q;
    pred_d    = pred_q;
    unique case (state_q)
      S_IDLE: begin
        if (!clr && any) begin
          id_d    = win;
          idx_d   = req_idx[int'(win)*IDX_W +: IDX_W];
          inc_d   = req_inc[win];
          gnt_d   = NREQ'(1) << win;
          state_d = S_RMW;
        end
      end
      S_RMW: begin
        rd_val_d = old_cnt;
        pred_d   = new_cnt[CNT_W-1];
        state_d  = S_ACK;
      end
      S_ACK: begin
        done_d    = 1'b1;
        done_id_d = id_q;
        rr_d      = (id_q == ID_W'(NREQ-1))
                    ? '0 : id_q + 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      idx_q     <= '0;
      inc_q     <= 1'b0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      rd_val_q  <= '0;
      pred_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      inc_q     <= inc_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      rd_val_q  <= rd_val_d;
      pred_q    <= pred_d;
    end
  end

  // clear beats a same-cycle writeback
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < DEPTH; i++)
        tbl_q[i] <= '0;
    end else if (state_q == S_RMW) begin
      tbl_q[idx_q] <= new_cnt;
    end
  end

`ifdef SAT_CNT_STATS_EN
  logic [15:0] sat_q;

  always_ff @(posedge clk) begin
    if (reset)
      sat_q <= '0;
    else if (state_q == S_RMW && sat)
      sat_q <= sat_q + 16'd1;
  end

  assign sat_hits = sat_q;
`endif

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign rd_val  = rd_val_q;
  assign pred    = pred_q;

endmodule

// File: tb/tb_sat_counter_arbiter.sv
// Scoreboard bench for sat_counter_arbiter.
// Directed ops push expectations; a monitor checks each done.
module tb_sat_counter_arbiter;

  localparam int NREQ  = 2;
  localparam int IDX_W = 4;
  localparam int CNT_W = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_inc;
  logic [NREQ*IDX_W-1:0] req_idx;
  logic                  clr;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [0:0]            done_id;
  logic [CNT_W-1:0]      rd_val;
  logic                  pred;
`ifdef SAT_CNT_STATS_EN
  logic [15:0]           sat_hits;
`endif

  sat_counter_arbiter #(
    .NREQ(NREQ), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_inc(req_inc),
    .req_idx(req_idx), .clr(clr),
    .gnt(gnt), .busy(busy), .done(done),
    .done_id(done_id), .rd_val(rd_val),
    .pred(pred)
`ifdef SAT_CNT_STATS_EN
    , .sat_hits(sat_hits)
`endif
  );

  typedef struct {
    int id;
    int rd;
    int pr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  task automatic push(input int id, input int rd,
                      input int pr);
    exp_t e;
    e.id = id;
    e.rd = rd;
    e.pr = pr;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got 1 want 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_id", 32'(done_id), e.id);
        chk("rd_val", 32'(rd_val), e.rd);
        chk("pred", 32'(pred), e.pr);
      end
    end
  end

  // one op from requester r; optional clr or reset in RMW
  task automatic op(input int r, input bit inc,
                    input int idx, input int erd,
                    input bit epr, input bit c_rmw,
                    input bit r_rmw);
    bit seen;
    if (!r_rmw) push(r, erd, int'(epr));
    req_inc[r] = inc;
    req_idx[r*IDX_W +: IDX_W] = IDX_W'(idx);
    req[r] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (gnt[r]) seen = 1'b1;
    end
    req[r] = 1'b0;
    if (!seen) fail("op_gnt");
    clr   = c_rmw;
    reset = r_rmw;
    @(posedge clk); #1;
    clr   = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int last;
    reset   = 1'b1;
    req     = '0;
    req_inc = '0;
    req_idx = '0;
    clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_id", 32'(done_id), 0);
    chk("rst_rd", 32'(rd_val), 0);
    chk("rst_pred", 32'(pred), 0);

    // 1: latency of a single inc
    push(0, 0, 0);
    req_inc[0] = 1'b1;
    req_idx[0 +: IDX_W] = 4'd3;
    req[0] = 1'b1;
    @(posedge clk); #1;
    chk("t1_gnt_c1", 32'(gnt), 1);
    chk("t1_busy", 32'(busy), 1);
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("t1_nodone_c2", 32'(done), 0);
    @(posedge clk); #1;
    chk("t1_done_c3", 32'(done), 1);

    // 2: count up to saturation
    op(0, 1, 3, 1, 1, 0, 0);
    op(0, 1, 3, 2, 1, 0, 0);
    op(0, 1, 3, 3, 1, 0, 0);
    op(0, 1, 3, 3, 1, 0, 0);
`ifdef SAT_CNT_STATS_EN
    chk("t2_sat", 32'(sat_hits), 1);
`endif
    op(0, 0, 3, 3, 1, 0, 0);

    // 3: dec on a zero entry
    op(1, 0, 10, 0, 0, 0, 0);
    op(1, 1, 10, 0, 0, 0, 0);
`ifdef SAT_CNT_STATS_EN
    chk("t3_sat", 32'(sat_hits), 2);
`endif

    // 4: both requesting continuously
    req_inc = 2'b11;
    req_idx[0 +: IDX_W] = 4'd8;
    req_idx[IDX_W +: IDX_W] = 4'd9;
    req = 2'b11;
    last = 0;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(posedge clk); #1;
        if (gnt != '0) seen = 1'b1;
      end
      if (!seen) fail("t4_gnt");
      chk("t4_gnt", 32'(gnt), (g % 2 == 0) ? 1 : 2);
      if (g > 0) chk("t4_gap", cyc - last, 3);
      last = cyc;
      push(g % 2, g / 2, g / 2);
      if (g == 3) req = '0;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end

    // 5: clr during RMW of idx 5 (old value 2)
    op(0, 1, 5, 0, 0, 0, 0);
    op(1, 1, 5, 1, 1, 0, 0);
    op(0, 1, 5, 2, 1, 1, 0);
    op(1, 1, 5, 0, 0, 0, 0);
    op(0, 1, 3, 0, 0, 0, 0);
`ifdef SAT_CNT_STATS_EN
    chk("t5_sat", 32'(sat_hits), 2);
`endif

    // 6: reset in RMW aborts the op
    op(0, 1, 7, 0, 0, 0, 0);
    op(1, 1, 7, 0, 0, 0, 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_rd", 32'(rd_val), 0);
`ifdef SAT_CNT_STATS_EN
    chk("t6_sat", 32'(sat_hits), 0);
`endif
    req_inc = 2'b11;
    req_idx[0 +: IDX_W] = 4'd7;
    req_idx[IDX_W +: IDX_W] = 4'd7;
    req = 2'b11;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); #1;
      if (gnt != '0) seen = 1'b1;
    end
    if (!seen) fail("t6_gnt");
    chk("t6_rr0", 32'(gnt), 1);
    req = '0;
    push(0, 0, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    op(1, 0, 7, 1, 0, 0, 0);

    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
